// File: rtl/fifo_read_ctrl_gray.sv
// Read-side pointer controller for a dual-clock FIFO: owns the read pointer,
// synchronises the write Gray pointer into r_clk and derives registered status flags.
module fifo_read_ctrl_gray #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THR      = 2
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic                  r_inc,
  input  logic [ADDR_WIDTH:0]   w_gptr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [ADDR_WIDTH:0]   r_gptr,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   r_level,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THR);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] r_sync [SYNC_STAGES];
  logic [PW-1:0] r_bin;

  logic [PW-1:0] w_wq;
  logic [PW-1:0] w_wBinSync;
  logic          w_rdEn;
  logic [PW-1:0] w_binNxt;
  logic [PW-1:0] w_grayNxt;
  logic [PW-1:0] w_lvlNxt;

  // Only the Gray-coded pointer crosses domains, so a stale sample is off by at most one.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= w_gptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_wq       = r_sync[SYNC_STAGES-1];
  assign w_wBinSync = gray2bin(w_wq);
  assign w_rdEn     = r_inc & ~empty;
  assign w_binNxt   = r_bin + PW'(w_rdEn);
  assign w_grayNxt  = w_binNxt ^ (w_binNxt >> 1);
  assign w_lvlNxt   = w_wBinSync - w_binNxt;

  // Status is computed from the post-read pointer so the last read flags empty on its own edge.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      r_bin        <= '0;
      r_addr       <= '0;
      r_gptr       <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      r_level      <= '0;
      underflow    <= 1'b0;
    end else begin
      r_bin        <= w_binNxt;
      r_addr       <= w_binNxt[ADDR_WIDTH-1:0];
      r_gptr       <= w_grayNxt;
      empty        <= (w_grayNxt == w_wq);
      almost_empty <= (w_lvlNxt <= AE_LIMIT);
      r_level      <= w_lvlNxt;
      underflow    <= r_inc & empty;
    end
  end

endmodule
